// File: rtl/gs_i2s_out.sv
// gs_i2s_out
//   Audio output stage for the General Sound block. It converts the two 15-bit
//   unsigned channel sums to signed 16-bit, optionally removes DC with a
//   first-order leaky integrator, and serialises the result as a Philips I2S
//   stream. Each frame is 64 BCLK long and carries a 16-bit word, MSB first,
//   in each 32-bit slot.
//
// Parameters
//   BCLK_DIV  clk_sys cycles per BCLK half-period (2..255)
//   DC_SHIFT  DC-blocker time constant as a shift amount (4..15)
//
// Ports
//   clk_sys        in   single clock for the whole block
//   areset_n       in   asynchronous active-low reset
//   in_l, in_r     in   15-bit unsigned channel samples
//   dc_en          in   1 = DC blocker active, 0 = bypass and clear accumulators
//   i2s_bclk       out  bit clock
//   i2s_lrck       out  word select (0 = left, 1 = right)
//   i2s_data       out  serial data, changes on falling BCLK
//   sample_strobe  out  one-cycle pulse when in_l/in_r are captured
module gs_i2s_out #(
  parameter int BCLK_DIV = 4,
  parameter int DC_SHIFT = 10
) (
  input  logic        clk_sys,
  input  logic        areset_n,
  input  logic [14:0] in_l,
  input  logic [14:0] in_r,
  input  logic        dc_en,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_data,
  output logic        sample_strobe
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam int ACC_W = 16 + DC_SHIFT;

  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [5:0]       bit_next;
  logic             div_tc;
  logic             fall_tick;
  logic             frame_wrap;

  logic [14:0]      cap_l;
  logic [14:0]      cap_r;
  logic             cap_dc;

  logic [15:0]      x_l;
  logic [15:0]      x_r;
  logic [15:0]      dc_l;
  logic [15:0]      dc_r;
  logic [16:0]      diff_l;
  logic [16:0]      diff_r;
  logic [ACC_W-1:0] acc_l;
  logic [ACC_W-1:0] acc_r;
  logic [15:0]      y_l;
  logic [15:0]      y_r;

  logic [4:0]       slot;
  logic [3:0]       bit_idx;
  logic [15:0]      ser_word;
  logic             ser_bit;

  // Clamp a 17-bit two's-complement value into the signed 16-bit range.
  function automatic logic [15:0] sat16(input logic [16:0] d);
    if (d[16] != d[15]) begin
      return d[16] ? 16'h8000 : 16'h7FFF;
    end
    return d[15:0];
  endfunction

  assign div_tc     = (div_cnt == DIV_LAST);
  assign fall_tick  = div_tc & i2s_bclk;
  assign bit_next   = bit_cnt + 6'd1;
  assign frame_wrap = fall_tick & (bit_cnt == 6'd63);
  assign i2s_lrck   = bit_cnt[5];

  // BCLK generator: toggle every BCLK_DIV system clocks.
  always_ff @(posedge clk_sys or negedge areset_n) begin
    if (!areset_n) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (div_tc) begin
      div_cnt  <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // Frame position advances on every falling BCLK, wrapping 63 -> 0.
  always_ff @(posedge clk_sys or negedge areset_n) begin
    if (!areset_n) begin
      bit_cnt <= '0;
    end else if (fall_tick) begin
      bit_cnt <= bit_next;
    end
  end

  // Both channels and the blocker enable are frozen together at frame start,
  // so anything the inputs do mid-frame cannot disturb the frame in flight.
  always_ff @(posedge clk_sys or negedge areset_n) begin
    if (!areset_n) begin
      cap_l         <= '0;
      cap_r         <= '0;
      cap_dc        <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= frame_wrap;
      if (frame_wrap) begin
        cap_l  <= in_l;
        cap_r  <= in_r;
        cap_dc <= dc_en;
      end
    end
  end

  // Subtracting 0x8000 from {in,0} recentres the unsigned sum around zero.
  // The accumulator slice starting at DC_SHIFT is its arithmetic right shift
  // truncated to 16 bits, which is all the DC estimate ever needs.
  assign x_l    = {cap_l, 1'b0} - 16'h8000;
  assign x_r    = {cap_r, 1'b0} - 16'h8000;
  assign dc_l   = acc_l[DC_SHIFT +: 16];
  assign dc_r   = acc_r[DC_SHIFT +: 16];
  assign diff_l = {x_l[15], x_l} - {dc_l[15], dc_l};
  assign diff_r = {x_r[15], x_r} - {dc_r[15], dc_r};

  // One cycle after capture the output words are computed from the old DC
  // estimate and the integrators absorb the unsaturated difference. In
  // bypass the integrators are parked at zero so re-enabling starts fresh.
  always_ff @(posedge clk_sys or negedge areset_n) begin
    if (!areset_n) begin
      y_l   <= '0;
      y_r   <= '0;
      acc_l <= '0;
      acc_r <= '0;
    end else if (sample_strobe) begin
      if (cap_dc) begin
        y_l   <= sat16(diff_l);
        y_r   <= sat16(diff_r);
        acc_l <= acc_l + {{(ACC_W-17){diff_l[16]}}, diff_l};
        acc_r <= acc_r + {{(ACC_W-17){diff_r[16]}}, diff_r};
      end else begin
        y_l   <= x_l;
        y_r   <= x_r;
        acc_l <= '0;
        acc_r <= '0;
      end
    end
  end

  // Serial bit for the slot being entered. Slots 1..16 carry the word MSB
  // first; 0 - slot[3:0] in 4 bits equals 16 - slot for that range.
  always_comb begin
    slot     = bit_next[4:0];
    bit_idx  = 4'd0 - slot[3:0];
    ser_word = bit_next[5] ? y_r : y_l;
    ser_bit  = 1'b0;
    if ((slot != 5'd0) && (slot <= 5'd16)) begin
      ser_bit = ser_word[bit_idx];
    end
  end

  // Data moves only with the falling BCLK so it is stable at the DAC's rising edge.
  always_ff @(posedge clk_sys or negedge areset_n) begin
    if (!areset_n) begin
      i2s_data <= 1'b0;
    end else if (fall_tick) begin
      i2s_data <= ser_bit;
    end
  end

endmodule
